stream_demux: RTL and testbench

Stream router/serializer on the output side of the pipeline; the inverse of the camera/SA input mux. It accepts 16-bit pixel words from the processing chain and routes them to one of two sinks: a 16-bit word sink, or an 8-bit byte sink. Words bound for the byte sink are split into two bytes, high byte first, matching OV7670 RGB565 byte order. Full valid/ready handshake on every port; each accepted word is routed whole by the `en` value sampled when it is accepted.

---
 rtl/stream_demux.sv | 106 ++++++++++
 tb/tb_stream_demux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux
//   Output-side stream router. Each accepted 16-bit word goes whole to
//   either the word sink (en=1) or the byte sink (en=0). On the byte sink
//   it is sent as two bytes, high byte first, which is the RGB565 order
//   the OV7670 side expects. All ports use a valid/ready handshake.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   en            route select, sampled when a word is accepted (1 = word, 0 = byte)
//   s_t*          16-bit input stream
//   word_t*       16-bit word sink
//   byte_t*       8-bit byte sink
//   busy          a word is held (state != IDLE)
module stream_demux (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [15:0] s_tdata,
    output logic        word_tvalid,
    input  logic        word_tready,
    output logic [15:0] word_tdata,
    output logic        byte_tvalid,
    input  logic        byte_tready,
    output logic [7:0]  byte_tdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WORD, BYTE_HI, BYTE_LO} state_t;

    state_t      state;
    logic [15:0] hold;
    logic        accept;

    // Ready is offered whenever the held word finishes on this edge, so a
    // new word can be loaded in the same cycle without a bubble.
    always_comb begin
        s_tready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    s_tready = 1'b1;
                WORD:    s_tready = word_tready;
                BYTE_LO: s_tready = byte_tready;
                default: s_tready = 1'b0;
            endcase
        end
    end

    assign accept = s_tvalid & s_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            word_tvalid <= 1'b0;
            word_tdata  <= '0;
            byte_tvalid <= 1'b0;
            byte_tdata  <= '0;
            busy        <= 1'b0;
        end else begin
            // Drain side first; a same-edge accept below overrides it.
            case (state)
                IDLE: ;
                WORD: begin
                    if (word_tready) begin
                        state       <= IDLE;
                        word_tvalid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                BYTE_HI: begin
                    if (byte_tready) begin
                        state      <= BYTE_LO;
                        byte_tdata <= hold[7:0];
                    end
                end
                BYTE_LO: begin
                    if (byte_tready) begin
                        state       <= IDLE;
                        byte_tvalid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                hold <= s_tdata;
                busy <= 1'b1;
                if (en) begin
                    state       <= WORD;
                    word_tvalid <= 1'b1;
                    word_tdata  <= s_tdata;
                    byte_tvalid <= 1'b0;
                end else begin
                    state       <= BYTE_HI;
                    byte_tvalid <= 1'b1;
                    byte_tdata  <= s_tdata[15:8];
                    word_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed cases with literal expectations, then
// randomized traffic checked every cycle against a queue-based model of
// pending output transfers.
module tb_stream_demux;

    logic        clk;
    logic        rst;
    logic        en;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        word_tvalid;
    logic        word_tready;
    logic [15:0] word_tdata;
    logic        byte_tvalid;
    logic        byte_tready;
    logic [7:0]  byte_tdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    stream_demux dut (
        .clk(clk), .rst(rst), .en(en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .word_tvalid(word_tvalid), .word_tready(word_tready), .word_tdata(word_tdata),
        .byte_tvalid(byte_tvalid), .byte_tready(byte_tready), .byte_tdata(byte_tdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of the output transfers still owed. A word accept
    // owes one word transfer, a byte accept owes two byte transfers.
    typedef struct {
        bit          is_word;
        logic [15:0] d;
    } item_t;

    item_t q[$];
    int    acc_word = 0, acc_byte = 0;   // accepts seen by the model
    int    xfer_word = 0, xfer_byte = 0; // handshakes seen on DUT outputs

    function automatic bit head_ready();
        if (q.size() == 0) return 1'b0;
        return q[0].is_word ? word_tready : byte_tready;
    endfunction

    // Input may be taken when nothing is owed, or when the only thing owed
    // completes on this edge.
    function automatic bit model_ready();
        return (q.size() == 0) || (q.size() == 1 && head_ready());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            bit    rdy;
            item_t it;
            rdy = model_ready();
            if (word_tvalid && word_tready) xfer_word++;
            if (byte_tvalid && byte_tready) xfer_byte++;
            if (head_ready()) void'(q.pop_front());
            if (s_tvalid && rdy) begin
                if (en) begin
                    it.is_word = 1'b1; it.d = s_tdata; q.push_back(it);
                    acc_word++;
                end else begin
                    it.is_word = 1'b0; it.d = {8'h00, s_tdata[15:8]}; q.push_back(it);
                    it.d = {8'h00, s_tdata[7:0]}; q.push_back(it);
                    acc_byte++;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        bit exp_wv, exp_bv;
        exp_wv = (q.size() != 0) && q[0].is_word;
        exp_bv = (q.size() != 0) && !q[0].is_word;
        chk("m_s_tready", s_tready, !rst && model_ready());
        chk("m_busy", busy, q.size() != 0);
        chk("m_word_tvalid", word_tvalid, exp_wv);
        chk("m_byte_tvalid", byte_tvalid, exp_bv);
        if (exp_wv) chk("m_word_tdata", word_tdata, q[0].d);
        if (exp_bv) chk("m_byte_tdata", byte_tdata, q[0].d);
    end

    // Inputs change 2 time units after the rising edge; peek lands on the
    // falling edge of the same cycle.
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic peek();
        #3;
    endtask

    initial begin
        int aw, ab, xw, xb;
        rst = 1'b1; en = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        word_tready = 1'b0; byte_tready = 1'b0;

        // Reset state
        #1;
        chk("rst_word_tvalid", word_tvalid, 0);
        chk("rst_byte_tvalid", byte_tvalid, 0);
        chk("rst_word_tdata", word_tdata, 0);
        chk("rst_byte_tdata", byte_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_tready", s_tready, 0);
        tick(); tick();
        rst = 1'b0;
        peek();
        chk("post_rst_s_tready", s_tready, 1);

        // Word path, back-to-back
        tick();
        en = 1'b1; word_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 16'h1234;
        tick();
        s_tdata = 16'hABCD;
        peek();
        chk("w1_valid", word_tvalid, 1);
        chk("w1_data", word_tdata, 16'h1234);
        chk("w1_ready", s_tready, 1);
        chk("w1_byte_valid", byte_tvalid, 0);
        tick();
        s_tvalid = 1'b0;
        peek();
        chk("w2_valid", word_tvalid, 1);
        chk("w2_data", word_tdata, 16'hABCD);
        chk("w2_byte_valid", byte_tvalid, 0);
        tick();
        peek();
        chk("w_idle_valid", word_tvalid, 0);

        // Byte path, sink always ready
        tick();
        en = 1'b0; byte_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 16'hF81F;
        tick();
        s_tvalid = 1'b0;
        peek();
        chk("b_hi_valid", byte_tvalid, 1);
        chk("b_hi_data", byte_tdata, 8'hF8);
        chk("b_hi_ready", s_tready, 0);
        chk("b_hi_word_valid", word_tvalid, 0);
        tick();
        peek();
        chk("b_lo_valid", byte_tvalid, 1);
        chk("b_lo_data", byte_tdata, 8'h1F);
        chk("b_lo_word_valid", word_tvalid, 0);
        tick();
        peek();
        chk("b_idle_valid", byte_tvalid, 0);

        // Byte path with backpressure on the high byte
        tick();
        byte_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 16'h07E0;
        tick();
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) byte_tready = 1'b1;
            peek();
            chk("bp_hi_valid", byte_tvalid, 1);
            chk("bp_hi_data", byte_tdata, 8'h07);
            chk("bp_busy", busy, 1);
            tick();
        end
        peek();
        chk("bp_lo_data", byte_tdata, 8'hE0);
        chk("bp_lo_busy", busy, 1);
        tick();
        peek();
        chk("bp_done_busy", busy, 0);

        // en flips while a byte word is held; next word goes to word sink
        tick();
        en = 1'b0; s_tvalid = 1'b1; s_tdata = 16'h1111;
        tick();
        s_tvalid = 1'b0; en = 1'b1;
        peek();
        chk("en_hi_data", byte_tdata, 8'h11);
        chk("en_hi_word_valid", word_tvalid, 0);
        tick();
        s_tvalid = 1'b1; s_tdata = 16'h2222;
        peek();
        chk("en_lo_valid", byte_tvalid, 1);
        chk("en_lo_data", byte_tdata, 8'h11);
        chk("en_lo_ready", s_tready, 1);
        tick();
        s_tvalid = 1'b0;
        peek();
        chk("en_word_valid", word_tvalid, 1);
        chk("en_word_data", word_tdata, 16'h2222);
        chk("en_word_byte_valid", byte_tvalid, 0);

        // Reset while the low byte of 0xBEEF is presented
        tick();
        en = 1'b0; s_tvalid = 1'b1; s_tdata = 16'hBEEF;
        tick();
        s_tvalid = 1'b0;
        tick();
        peek();
        chk("rb_lo_data", byte_tdata, 8'hEF);
        #2;                    // mid-cycle, before the next edge
        rst = 1'b1;
        #1;
        chk("rb_byte_valid", byte_tvalid, 0);
        chk("rb_busy", busy, 0);
        chk("rb_s_tready", s_tready, 0);
        tick();
        rst = 1'b0;
        peek();
        chk("rb_after_byte_valid", byte_tvalid, 0);
        tick();
        en = 1'b1; s_tvalid = 1'b1; s_tdata = 16'h5A5A;
        tick();
        s_tvalid = 1'b0;
        peek();
        chk("rb_next_word_valid", word_tvalid, 1);
        chk("rb_next_word_data", word_tdata, 16'h5A5A);
        tick();

        // Randomized traffic
        aw = acc_word; ab = acc_byte; xw = xfer_word; xb = xfer_byte;
        for (int i = 0; i < 10000; i++) begin
            s_tvalid    = 1'($urandom_range(0, 1));
            s_tdata     = 16'($urandom);
            en          = 1'($urandom_range(0, 1));
            word_tready = ($urandom_range(0, 3) != 0);
            byte_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_tvalid = 1'b0; word_tready = 1'b1; byte_tready = 1'b1;
        repeat (4) tick();
        peek();
        chk("rnd_drained_busy", busy, 0);
        total++;
        if ((xfer_word - xw) != (acc_word - aw)) begin
            bad++;
            $display("FAIL rnd_word_count: got %0d transfers expected %0d",
                     xfer_word - xw, acc_word - aw);
        end
        total++;
        if ((xfer_byte - xb) != 2 * (acc_byte - ab)) begin
            bad++;
            $display("FAIL rnd_byte_count: got %0d transfers expected %0d",
                     xfer_byte - xb, 2 * (acc_byte - ab));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
